// File: rtl/cla_pkg.sv
// Shared constants and geometry helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Number of lookahead groups that tile the operand word.
    function automatic int group_count(input int width, input int block);
        return width / block;
    endfunction

    // Groups must tile the word exactly and stay within the supported sizes.
    function automatic bit geometry_ok(input int width, input int block);
        return (width % block == 0) &&
               (block == 2 || block == 4 || block == 8) &&
               (width >= 8) && (width <= 128);
    endfunction

endpackage

// File: rtl/cla_block.sv
// One lookahead group: flat sum-of-products carries from local generate/propagate,
// plus the group generate/propagate used by the next lookahead level.
module cla_block
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] g,
    input  logic [BLOCK-1:0] p,
    input  logic             cin,
    output logic             gg,
    output logic             gp,
    output logic [BLOCK-1:0] carries
);

    // AND of pv[lo..hi]; an empty span (hi < lo) propagates unconditionally.
    function automatic logic p_span(input logic [BLOCK-1:0] pv, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int k = lo; k <= hi; k++) begin
            r = r & pv[k];
        end
        return r;
    endfunction

    // Carry into bit position i, expanded without any ripple through lower carries.
    function automatic logic carry_into(input logic [BLOCK-1:0] gv, input logic [BLOCK-1:0] pv,
                                        input logic c, input int i);
        logic r;
        r = c & p_span(pv, 0, i - 1);
        for (int j = 0; j < i; j++) begin
            r = r | (gv[j] & p_span(pv, j + 1, i - 1));
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        carries = '0;
        for (int i = 0; i < BLOCK; i++) begin
            carries[i] = carry_into(g, p, cin, i);
        end
        // Carry out of the group with a zero carry-in is exactly the group generate.
        gg = carry_into(g, p, 1'b0, BLOCK);
        gp = p_span(p, 0, BLOCK - 1);
    end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready stream
// interface: S1 registers bit and group generate/propagate, S2 resolves carries and sums.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NG = group_count(WIDTH, BLOCK);

    if (!geometry_ok(WIDTH, BLOCK)) begin : g_bad_geometry
        $fatal(1, "pipelined_cla_adder: WIDTH must be a multiple of BLOCK (2/4/8) within 8..128");
    end

    // ------------------------------------------------------------------
    // Handshake: a ready chain back from out_ready, no skid buffering.
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_ready;
    logic s1_advance;
    logic in_fire;

    assign s2_ready   = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_ready;
    assign in_ready   = rst_n && (!s1_valid || s1_advance);
    assign in_fire    = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Stage 1: subtract folds into the operands, then per-bit and per-group g/p.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] p_in;
    logic             c0_in;
    logic [NG-1:0]    gg_in;
    logic [NG-1:0]    gp_in;
    logic [WIDTH-1:0] s1_carries_unused;

    assign b_eff = (mode == MODE_SUB) ? ~b : b;
    assign g_in  = a & b_eff;
    assign p_in  = a ^ b_eff;
    assign c0_in = (mode == MODE_SUB) ? ~cin : cin;

    for (genvar i = 0; i < NG; i++) begin : g_s1_group
        cla_block #(.BLOCK(BLOCK)) u_group_gp (
            .g       (g_in[i*BLOCK +: BLOCK]),
            .p       (p_in[i*BLOCK +: BLOCK]),
            .cin     (1'b0),
            .gg      (gg_in[i]),
            .gp      (gp_in[i]),
            .carries (s1_carries_unused[i*BLOCK +: BLOCK])
        );
    end

    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic             s1_c0;
    logic [NG-1:0]    s1_gg;
    logic [NG-1:0]    s1_gp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid <= 1'b0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_c0    <= 1'b0;
            s1_gg    <= '0;
            s1_gp    <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            // Data only moves on a real transfer, so idle cycles leave the registers quiet.
            if (in_fire) begin
                s1_g  <= g_in;
                s1_p  <= p_in;
                s1_c0 <= c0_in;
                s1_gg <= gg_in;
                s1_gp <= gp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: second-level lookahead gives group carry-ins, groups expand them.
    // ------------------------------------------------------------------
    logic [NG-1:0]    grp_cin;
    logic             top_g;
    logic             top_p;
    logic [NG-1:0]    grp_g_unused;
    logic [NG-1:0]    grp_p_unused;
    logic [WIDTH-1:0] bit_c;
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             ovf_next;

    cla_block #(.BLOCK(NG)) u_group_carry (
        .g       (s1_gg),
        .p       (s1_gp),
        .cin     (s1_c0),
        .gg      (top_g),
        .gp      (top_p),
        .carries (grp_cin)
    );

    for (genvar i = 0; i < NG; i++) begin : g_s2_group
        cla_block #(.BLOCK(BLOCK)) u_bit_carry (
            .g       (s1_g[i*BLOCK +: BLOCK]),
            .p       (s1_p[i*BLOCK +: BLOCK]),
            .cin     (grp_cin[i]),
            .gg      (grp_g_unused[i]),
            .gp      (grp_p_unused[i]),
            .carries (bit_c[i*BLOCK +: BLOCK])
        );
    end

    assign cout_next = top_g | (top_p & s1_c0);
    assign sum_next  = s1_p ^ bit_c;
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    assign ovf_next  = bit_c[WIDTH-1] ^ cout_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: result registers are reset as well so sum/cout/overflow read 0 in reset.
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (s2_ready) begin
                out_valid <= s1_valid;
            end
            if (s1_advance) begin
                sum      <= sum_next;
                cout     <= cout_next;
                overflow <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed vector table, backpressure and
// mid-flight reset sequences, and scoreboarded streams on 32/4 and 64/8 instances.
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] a_drv = '0;
    logic [127:0] b_drv = '0;
    logic         cin_drv = 1'b0;
    logic         mode_drv = 1'b0;
    logic         in_valid_drv = 1'b0;
    logic         out_ready_drv = 1'b1;
    logic         use64 = 1'b0;

    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] sum32;
    logic        in_ready64, out_valid64, cout64, ovf64;
    logic [63:0] sum64;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(4)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_drv & ~use64),
        .in_ready  (in_ready32),
        .a         (a_drv[31:0]),
        .b         (b_drv[31:0]),
        .cin       (cin_drv),
        .mode      (mode_drv),
        .out_valid (out_valid32),
        .out_ready (out_ready_drv | use64),
        .sum       (sum32),
        .cout      (cout32),
        .overflow  (ovf32)
    );

    pipelined_cla_adder #(.WIDTH(64), .BLOCK(8)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_drv & use64),
        .in_ready  (in_ready64),
        .a         (a_drv[63:0]),
        .b         (b_drv[63:0]),
        .cin       (cin_drv),
        .mode      (mode_drv),
        .out_valid (out_valid64),
        .out_ready (out_ready_drv | ~use64),
        .sum       (sum64),
        .cout      (cout64),
        .overflow  (ovf64)
    );

    always #5 clk = ~clk;

    logic         cur_in_ready, cur_out_valid, cur_cout, cur_ovf;
    logic [127:0] cur_sum;

    always_comb begin
        cur_in_ready  = use64 ? in_ready64  : in_ready32;
        cur_out_valid = use64 ? out_valid64 : out_valid32;
        cur_cout      = use64 ? cout64      : cout32;
        cur_ovf       = use64 ? ovf64       : ovf32;
        cur_sum       = use64 ? {64'd0, sum64} : {96'd0, sum32};
    end

    int   n_tests = 0;
    int   n_fail = 0;
    int   n_results = 0;
    res_t exp_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result sign rule.
    function automatic res_t model(input logic [127:0] a, input logic [127:0] b,
                                   input logic ci, input logic m, input int w);
        res_t         r;
        logic [128:0] mask;
        logic [128:0] full;
        logic [127:0] am;
        logic [127:0] bm;
        logic         c;
        mask   = (129'd1 << w) - 129'd1;
        am     = a & mask[127:0];
        bm     = (m ? ~b : b) & mask[127:0];
        c      = m ? ~ci : ci;
        full   = {1'b0, am} + {1'b0, bm} + {128'd0, c};
        r.sum  = full[127:0] & mask[127:0];
        r.cout = full[w];
        r.ovf  = (am[w-1] == bm[w-1]) && (r.sum[w-1] != am[w-1]);
        return r;
    endfunction

    function automatic logic [127:0] pick();
        case ($urandom_range(0, 9))
            0:       return '1;
            1:       return '0;
            2:       return {4{32'h8000_0000}};
            3:       return {4{32'h7FFF_FFFF}};
            default: return {$urandom, $urandom, $urandom, $urandom};
        endcase
    endfunction

    // One clock: score the visible result, drive new inputs, note accept/drain.
    task automatic step(input logic v, input logic [127:0] a, input logic [127:0] b,
                        input logic ci, input logic m, input logic ordy, output logic acc);
        res_t want;
        @(negedge clk);
        if (cur_out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {127'd0, cur_out_valid}, 128'd0);
            end else begin
                want = exp_q[0];
                check("sb_sum", cur_sum, want.sum);
                check("sb_cout", {127'd0, cur_cout}, {127'd0, want.cout});
                check("sb_ovf", {127'd0, cur_ovf}, {127'd0, want.ovf});
            end
        end
        in_valid_drv  = v;
        a_drv         = a;
        b_drv         = b;
        cin_drv       = ci;
        mode_drv      = m;
        out_ready_drv = ordy;
        #1;
        acc = v && cur_in_ready;
        if (cur_out_valid && ordy && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            n_results++;
        end
        if (acc) exp_q.push_back(model(a, b, ci, m, use64 ? 64 : 32));
    endtask

    task automatic stream(input logic wide, input logic m, input int n);
        int   acc_cnt;
        int   busy;
        int   res_start;
        logic acc;
        use64     = wide;
        acc_cnt   = 0;
        busy      = 0;
        res_start = n_results;
        for (int i = 0; i < n; i++) begin
            step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), m, 1'b1, acc);
            if (acc) acc_cnt++;
            if (i >= 2 && cur_out_valid) busy++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, m, 1'b1, acc);
        check(wide ? "stream64_accepts" : "stream32_accepts", 128'(acc_cnt), 128'(n));
        check(wide ? "stream64_full_rate" : "stream32_full_rate", 128'(busy), 128'(n - 2));
        check(wide ? "stream64_results" : "stream32_results", 128'(n_results - res_start), 128'(n));
        check(wide ? "stream64_drained" : "stream32_drained", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic acc;
        int   bp_idx;
        int   res_start;

        vecs.push_back('{"add_wrap",      MODE_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{"add_ovf",       MODE_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{"sub_ovf",       MODE_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1});
        vecs.push_back('{"sub_borrow_in", MODE_SUB, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b1, 1'b0});
        vecs.push_back('{"add_cin",       MODE_ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0});
        vecs.push_back('{"sub_underflow", MODE_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"add_group_run", MODE_ADD, 32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 32'h1000_0000, 1'b0, 1'b0});
        vecs.push_back('{"sub_neg_one",   MODE_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{"add_neg_ovf",   MODE_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{"sub_self_bin",  MODE_SUB, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid32}, 128'd0);
        check("rst_sum", {96'd0, sum32}, 128'd0);
        check("rst_cout", {127'd0, cout32}, 128'd0);
        check("rst_overflow", {127'd0, ovf32}, 128'd0);
        check("rst_in_ready32", {127'd0, in_ready32}, 128'd0);
        check("rst_in_ready64", {127'd0, in_ready64}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", {127'd0, in_ready32}, 128'd1);

        // Directed vectors with exact 2-cycle latency
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            in_valid_drv  = 1'b1;
            a_drv         = {96'd0, vecs[i].a};
            b_drv         = {96'd0, vecs[i].b};
            cin_drv       = vecs[i].cin;
            mode_drv      = vecs[i].mode;
            out_ready_drv = 1'b1;
            #1 check({vecs[i].name, "_in_ready"}, {127'd0, cur_in_ready}, 128'd1);
            @(negedge clk);
            in_valid_drv = 1'b0;
            a_drv        = {$urandom, $urandom, $urandom, $urandom};
            b_drv        = {$urandom, $urandom, $urandom, $urandom};
            cin_drv      = ~vecs[i].cin;
            mode_drv     = ~vecs[i].mode;
            check({vecs[i].name, "_early"}, {127'd0, cur_out_valid}, 128'd0);
            @(negedge clk);
            check({vecs[i].name, "_valid"}, {127'd0, cur_out_valid}, 128'd1);
            check({vecs[i].name, "_sum"}, cur_sum, {96'd0, vecs[i].sum});
            check({vecs[i].name, "_cout"}, {127'd0, cur_cout}, {127'd0, vecs[i].cout});
            check({vecs[i].name, "_ovf"}, {127'd0, cur_ovf}, {127'd0, vecs[i].ovf});
        end
        @(negedge clk);

        // Backpressure: three beats offered while the sink stalls for 6 cycles
        bp_idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(bp_idx < 3, 128'(bp_idx + 1), 128'(bp_idx + 1), 1'b0, MODE_ADD, 1'b0, acc);
            if (acc) bp_idx++;
            if (c >= 2) begin
                check("bp_in_ready_low", {127'd0, cur_in_ready}, 128'd0);
                check("bp_hold_valid", {127'd0, cur_out_valid}, 128'd1);
                check("bp_hold_sum", cur_sum, 128'd2);
            end
        end
        check("bp_accepts_stalled", 128'(bp_idx), 128'd2);
        res_start = n_results;
        for (int c = 0; c < 4; c++) begin
            step(bp_idx < 3, 128'(bp_idx + 1), 128'(bp_idx + 1), 1'b0, MODE_ADD, 1'b1, acc);
            if (acc) bp_idx++;
            if (c == 0) check("bp_accept_and_drain", {127'd0, cur_in_ready}, 128'd1);
            check("bp_drain_cadence", {127'd0, cur_out_valid}, {127'd0, c < 3});
        end
        check("bp_results", 128'(n_results - res_start), 128'd3);
        check("bp_drained", 128'(exp_q.size()), 128'd0);

        // Random streaming on both geometries and both modes
        stream(1'b0, MODE_ADD, 1000);
        stream(1'b0, MODE_SUB, 1000);
        stream(1'b1, MODE_ADD, 1000);
        stream(1'b1, MODE_SUB, 1000);
        use64 = 1'b0;

        // Reset with two beats in flight
        step(1'b1, 128'd11, 128'd22, 1'b0, MODE_ADD, 1'b1, acc);
        step(1'b1, 128'd33, 128'd44, 1'b0, MODE_ADD, 1'b1, acc);
        @(posedge clk);
        #2;
        in_valid_drv = 1'b0;
        check("mid_rst_precond", {127'd0, cur_out_valid}, 128'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {127'd0, cur_out_valid}, 128'd0);
        check("mid_rst_sum", cur_sum, 128'd0);
        check("mid_rst_cout", {127'd0, cur_cout}, 128'd0);
        check("mid_rst_in_ready", {127'd0, cur_in_ready}, 128'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, '0, '0, 1'b0, MODE_ADD, 1'b1, acc);
            check("post_rst_idle", {127'd0, cur_out_valid}, 128'd0);
        end
        res_start = n_results;
        step(1'b1, 128'd9, 128'd6, 1'b0, MODE_SUB, 1'b1, acc);
        check("post_rst_accept", {127'd0, acc}, 128'd1);
        for (int c = 0; c < 3; c++) step(1'b0, '0, '0, 1'b0, MODE_ADD, 1'b1, acc);
        check("post_rst_result", 128'(n_results - res_start), 128'd1);
        check("post_rst_drained", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
